magnitude_tracker: RTL
======================

// Module: magnitude_tracker
// PURPOSE
//  Downstream consumer of the x/y magnitude stage (approx. sqrt(x^2+y^2)). Accepts magnitude
//  samples over a valid/ready handshake, computes a non-overlapping block average over
//  2^LOG2_WIN samples, and drives a debounced alarm with hysteresis (thr_hi / thr_lo).
//  Optional peak-hold register for diagnostics.
// PARAMETERS
//  W         8  magnitude sample width (bits)
//  LOG2_WIN  2  log2 of averaging window length (window = 2^LOG2_WIN samples, LOG2_WIN >= 1)
//  DEBOUNCE  3  consecutive qualifying averages required to change alarm state (>= 1)
// PORTS
//  clk         in   1          clock, rising edge
//  rst_n       in   1          reset, asynchronous, active-low
//  ena         in   1          block enable; low = freeze all state
//  mag_valid   in   1          mag_in holds a valid sample
//  mag_in      in   W          magnitude sample from upstream stage
//  mag_ready   out  1          sample accepted on clock edge when mag_valid & mag_ready
//  thr_hi      in   W          alarm assert threshold (avg >= thr_hi qualifies)
//  thr_lo      in   W          alarm release threshold (avg <= thr_lo qualifies)
//  peak_clr    in   1          clear peak register (feature-dependent)
//  avg_out     out  W          latest window average, held until next window completes
//  avg_valid   out  1          one-cycle pulse: avg_out updated
//  alarm       out  1          debounced alarm level
//  alarm_edge  out  1          one-cycle pulse on any alarm transition
//  peak_out    out  W          max accepted sample since reset/clear (feature-dependent)
// BEHAVIOUR
//  - Reset: acc, window counter, debounce counter = 0; FSM = LOW; avg_out, avg_valid, alarm,
//    alarm_edge, peak_out = 0. mag_ready is combinational = ena (also 0 while rst_n low).
//  - Accumulator width W+LOG2_WIN, never overflows. On accepted sample: acc += mag_in, cnt++.
//  - On accepting the 2^LOG2_WIN-th sample: avg_out <= (acc + mag_in) >> LOG2_WIN (truncate),
//    avg_valid = 1 for exactly the following cycle, acc and cnt cleared same edge.
//  - Gaps in mag_valid allowed; only accepted samples count. No timeout on partial windows.
//  - Alarm FSM advances only on the edge that produces a new average (uses that new avg):
//    LOW:     avg>=thr_hi -> (DEBOUNCE==1 ? HIGH : PEND_HI, dcnt=1); else stay.
//    PEND_HI: avg>=thr_hi -> dcnt++, at dcnt==DEBOUNCE go HIGH; avg<thr_hi -> LOW, dcnt=0.
//    HIGH:    avg<=thr_lo -> (DEBOUNCE==1 ? LOW : PEND_LO, dcnt=1); else stay.
//    PEND_LO: avg<=thr_lo -> dcnt++, at dcnt==DEBOUNCE go LOW; avg>thr_lo -> HIGH, dcnt=0.
//  - alarm = 1 in HIGH and PEND_LO; registered, changes in the same cycle avg_valid is high.
//    alarm_edge pulses that same cycle on either transition.
//  - Threshold sanity: if thr_lo >= thr_hi, effective release threshold = thr_hi-1
//    (0 when thr_hi==0). thr_hi==0 -> every average qualifies high.
//  - Thresholds sampled combinationally at evaluation edge; no latching.
//  - ena low: no acceptance, acc/cnt/FSM/peak frozen, avg_valid and alarm_edge forced 0;
//    avg_out, alarm, peak_out hold. Resuming continues the partial window.
//  - Reset mid-window discards partial sum; first window after reset starts from 0.
// CONFIGURATION
//  MAG_TRACK_PEAK_EN defined: peak_out <= max(peak_out, mag_in) on each accepted sample.
//    peak_clr (ena high) -> peak_out <= 0; if a sample is accepted the same edge,
//    peak_out <= mag_in (clear then load). Reset clears peak.
//  MAG_TRACK_PEAK_EN undefined: no peak register, peak_out tied 0, peak_clr ignored.
// TESTING (defaults W=8, LOG2_WIN=2, DEBOUNCE=3 unless noted)
//  1 Reset/enable: assert rst_n=0 mid-operation -> all outputs 0 immediately; ena=0 -> mag_ready=0.
//  2 Average: accept 10,20,30,41 -> avg_out=25 (101>>2), avg_valid one cycle, then 4x255
//    -> avg_out=255; valid gaps of 1-5 idle cycles between samples give same results.
//  3 Hysteresis: thr_hi=50, thr_lo=30; averages 60,60,60 -> alarm=1 + alarm_edge on 3rd;
//    40 -> alarm stays 1; 20,20,20 -> alarm=0 + alarm_edge on 3rd.
//  4 Debounce abort: averages 60,60,40,60,60 -> alarm stays 0; thr_lo=70,thr_hi=50 -> release at <=49.
//  5 Freeze/reset: accept 8,8; ena=0 for 5 cycles with mag_valid=1; ena=1, accept 8,8 -> avg 8
//    after 4th accepted only; accept 2 samples, pulse rst_n, accept 4x4 -> avg_out=4.
//  6 Peak (macro on): accept 5,200,7 -> peak_out=200; peak_clr with sample 9 -> 9;
//    macro off -> peak_out=0 throughout.

Source files
------------

// File: rtl/magnitude_tracker.sv
// magnitude_tracker: block averager over 2^LOG2_WIN accepted magnitude samples,
// feeding a debounced hysteresis alarm FSM.
// Optional peak-hold register is enabled by defining MAG_TRACK_PEAK_EN.
// Handshake: a sample transfers on a rising clk edge where mag_valid && mag_ready;
// mag_ready is simply ena (and low while rst_n is low), so nothing else stalls input.
// dbg_state_o exposes the alarm FSM: 0=LOW 1=PEND_HI 2=HIGH 3=PEND_LO.
module magnitude_tracker #(
   parameter int W        = 8,
   parameter int LOG2_WIN = 2,
   parameter int DEBOUNCE = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ena,
   input  logic         mag_valid,
   input  logic [W-1:0] mag_in,
   output logic         mag_ready,
   input  logic [W-1:0] thr_hi,
   input  logic [W-1:0] thr_lo,
   input  logic         peak_clr,
   output logic [W-1:0] avg_out,
   output logic         avg_valid,
   output logic         alarm,
   output logic         alarm_edge,
   output logic [W-1:0] peak_out,
   output logic [1:0]   dbg_state_o
);

   localparam int AW = W + LOG2_WIN;
   localparam int DW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);

   typedef enum logic [1:0] {
      ST_LOW     = 2'd0,
      ST_PEND_HI = 2'd1,
      ST_HIGH    = 2'd2,
      ST_PEND_LO = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [DW-1:0]       dcnt_q, dcnt_d;
   logic [AW-1:0]       acc_q, acc_d;
   logic [AW-1:0]       sum;
   logic [LOG2_WIN-1:0] cnt_q, cnt_d;
   logic [W-1:0]        avg_q, avg_d;
   logic                avg_valid_q;
   logic                alarm_q, alarm_d;
   logic                edge_q, edge_d;
   logic                accept;
   logic                win_done;
   logic [W-1:0]        lo_eff;
   logic                qual_hi;
   logic                qual_lo;

   assign mag_ready = ena & rst_n;
   assign accept    = mag_valid & mag_ready;
   assign sum       = acc_q + AW'(mag_in);
   assign win_done  = accept & (cnt_q == '1);

   // Accumulator / window counter next state and the new average on window completion
   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      avg_d = avg_q;
      if (accept) begin
         if (win_done) begin
            acc_d = '0;
            cnt_d = '0;
            avg_d = sum[AW-1:LOG2_WIN];
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Release threshold is pulled below thr_hi when the pair is inverted, so hysteresis never collapses
   always_comb begin
      lo_eff = thr_lo;
      if (thr_lo >= thr_hi) begin
         lo_eff = (thr_hi == '0) ? '0 : (thr_hi - W'(1));
      end
      qual_hi = (avg_d >= thr_hi);
      qual_lo = (avg_d <= lo_eff);
   end

   // Alarm FSM next state; only evaluated on the edge that produces a new average
   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      if (win_done) begin
         case (state_q)
            ST_LOW: begin
               if (qual_hi) begin
                  if (DEBOUNCE == 1) begin
                     state_d = ST_HIGH;
                  end else begin
                     state_d = ST_PEND_HI;
                     dcnt_d  = DW'(1);
                  end
               end
            end
            ST_PEND_HI: begin
               if (qual_hi) begin
                  if ((dcnt_q + DW'(1)) == DW'(DEBOUNCE)) begin
                     state_d = ST_HIGH;
                     dcnt_d  = '0;
                  end else begin
                     dcnt_d  = dcnt_q + DW'(1);
                  end
               end else begin
                  state_d = ST_LOW;
                  dcnt_d  = '0;
               end
            end
            ST_HIGH: begin
               if (qual_lo) begin
                  if (DEBOUNCE == 1) begin
                     state_d = ST_LOW;
                  end else begin
                     state_d = ST_PEND_LO;
                     dcnt_d  = DW'(1);
                  end
               end
            end
            ST_PEND_LO: begin
               if (qual_lo) begin
                  if ((dcnt_q + DW'(1)) == DW'(DEBOUNCE)) begin
                     state_d = ST_LOW;
                     dcnt_d  = '0;
                  end else begin
                     dcnt_d  = dcnt_q + DW'(1);
                  end
               end else begin
                  state_d = ST_HIGH;
                  dcnt_d  = '0;
               end
            end
            default: begin
               state_d = ST_LOW;
               dcnt_d  = '0;
            end
         endcase
      end
      alarm_d = (state_d == ST_HIGH) || (state_d == ST_PEND_LO);
      edge_d  = win_done & (alarm_d != alarm_q);
   end

   // State registers; ena low freezes everything and kills the pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_LOW;
         dcnt_q      <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         avg_q       <= '0;
         avg_valid_q <= 1'b0;
         alarm_q     <= 1'b0;
         edge_q      <= 1'b0;
      end else if (ena) begin
         state_q     <= state_d;
         dcnt_q      <= dcnt_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         avg_q       <= avg_d;
         avg_valid_q <= win_done;
         alarm_q     <= alarm_d;
         edge_q      <= edge_d;
      end else begin
         avg_valid_q <= 1'b0;
         edge_q      <= 1'b0;
      end
   end

   assign avg_out     = avg_q;
   assign avg_valid   = avg_valid_q & ena;
   assign alarm       = alarm_q;
   assign alarm_edge  = edge_q & ena;
   assign dbg_state_o = state_q;

`ifdef MAG_TRACK_PEAK_EN
   logic [W-1:0] peak_q;

   // Peak hold: clear-then-load when a clear coincides with an accepted sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peak_q <= '0;
      end else if (ena) begin
         if (peak_clr) begin
            peak_q <= accept ? mag_in : '0;
         end else if (accept && (mag_in > peak_q)) begin
            peak_q <= mag_in;
         end
      end
   end

   assign peak_out = peak_q;
`else
   logic unused_peak_clr;

   assign unused_peak_clr = peak_clr;
   assign peak_out        = '0;
`endif

endmodule
